// File: rtl/add32_pipe_pkg.sv
// Shared definitions for the pipelined adder/subtractor and its consumers.
package add32_pipe_pkg;

   // Default operand width; must stay a multiple of GRP_W.
   localparam int unsigned WIDTH_DEF = 32;

   // Width of one carry-lookahead group.
   localparam int unsigned GRP_W = 4;

   // Result flags, also consumed by the ALU result mux.
   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
      logic neg;
   } flags_t;

endpackage

// File: rtl/add32_pipe_cla_grp4.sv
// 4-bit carry-lookahead group: internal carries plus group propagate/generate.
module cla_grp4
   import add32_pipe_pkg::*;
(
   input  logic [GRP_W-1:0] p,
   input  logic [GRP_W-1:0] g,
   input  logic             cin,
   output logic [GRP_W:1]   c,
   output logic             ps,
   output logic             gs
);

   // Flat two-level lookahead; every carry is a direct sum of products.
   always_comb begin
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      ps   = &p;
      gs   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   end

endmodule

// File: rtl/add32_pipe.sv
// Two-stage pipelined adder/subtractor built on 4-bit lookahead groups.
// Stage 1 holds operands and group PS/GS; stage 2 resolves group carries and
// registers the sum and flags. Both stages are plain registers with
// valid/ready flow control and no skid buffer.
module add32_pipe
   import add32_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int unsigned NGRP = WIDTH / GRP_W;

   // Flow control
   logic s1_adv;
   logic s2_adv;

   // Stage-1 inputs
   logic [WIDTH-1:0] bb_in;
   logic [WIDTH-1:0] p_in;
   logic [WIDTH-1:0] g_in;
   logic             c0_in;
   logic [NGRP-1:0]  ps_in;
   logic [NGRP-1:0]  gs_in;
   logic [WIDTH-1:0] s1_c_unused;

   // Stage-1 registers
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_bb;
   logic [WIDTH-1:0] s1_p;
   logic [WIDTH-1:0] s1_g;
   logic             s1_c0;
   logic [NGRP-1:0]  s1_ps;
   logic [NGRP-1:0]  s1_gs;

   // Stage-2 combinational
   logic [NGRP:0]    grp_c;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_d;
   flags_t           flags_d;
   logic [NGRP-1:0]  s2_ps_unused;
   logic [NGRP-1:0]  s2_gs_unused;

   // Output registers
   flags_t           flags_q;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // Operands are kept in stage 1 for debug visibility; the adder itself
   // works only from p/g.
   logic s1_data_unused;
   assign s1_data_unused = ^{s1_a, s1_bb};

   // Effective operands and per-bit propagate/generate.
   always_comb begin
      bb_in = sub ? ~b : b;
      c0_in = sub | cin;
      p_in  = a ^ bb_in;
      g_in  = a & bb_in;
   end

   // Stage-1 groups: only PS/GS are needed here.
   for (genvar k = 0; k < NGRP; k++) begin : g_s1_grp
      cla_grp4 u_cla (
         .p   (p_in[GRP_W*k +: GRP_W]),
         .g   (g_in[GRP_W*k +: GRP_W]),
         .cin (1'b0),
         .c   (s1_c_unused[GRP_W*k +: GRP_W]),
         .ps  (ps_in[k]),
         .gs  (gs_in[k])
      );
   end

   // Stage-1 register: load a new beat whenever the stage can advance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_bb    <= '0;
         s1_p     <= '0;
         s1_g     <= '0;
         s1_c0    <= 1'b0;
         s1_ps    <= '0;
         s1_gs    <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a  <= a;
            s1_bb <= bb_in;
            s1_p  <= p_in;
            s1_g  <= g_in;
            s1_c0 <= c0_in;
            s1_ps <= ps_in;
            s1_gs <= gs_in;
         end
      end
   end

   // Second-level lookahead: each group carry-in is a flat sum of products
   // of PS/GS and c0, so no carry ripples from group to group.
   assign grp_c[0] = s1_c0;
   for (genvar k = 1; k <= NGRP; k++) begin : g_lvl2
      logic ck;
      // Group carry-in k from all lower-group PS/GS terms.
      always_comb begin
         logic term;
         term = 1'b0;
         ck   = s1_c0 & (&s1_ps[k-1:0]);
         for (int j = 0; j < k; j++) begin
            term = s1_gs[j];
            for (int m = j + 1; m < k; m++) begin
               term = term & s1_ps[m];
            end
            ck = ck | term;
         end
      end
      assign grp_c[k] = ck;
   end

   // Stage-2 groups: intra-group carries from the resolved group carry-ins.
   assign carry[0] = s1_c0;
   for (genvar k = 0; k < NGRP; k++) begin : g_s2_grp
      cla_grp4 u_cla (
         .p   (s1_p[GRP_W*k +: GRP_W]),
         .g   (s1_g[GRP_W*k +: GRP_W]),
         .cin (grp_c[k]),
         .c   (carry[GRP_W*k+1 +: GRP_W]),
         .ps  (s2_ps_unused[k]),
         .gs  (s2_gs_unused[k])
      );
   end

   // Sum and flags from the carry chain.
   always_comb begin
      sum_d        = s1_p ^ carry[WIDTH-1:0];
      flags_d.cout = grp_c[NGRP];
      flags_d.ovf  = carry[WIDTH] ^ carry[WIDTH-1];
      flags_d.zero = ~|sum_d;
      flags_d.neg  = sum_d[WIDTH-1];
   end

   // Output register: data changes only when a stage-1 beat moves forward.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         flags_q   <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            sum     <= sum_d;
            flags_q <= flags_d;
         end
      end
   end

   assign cout = flags_q.cout;
   assign ovf  = flags_q.ovf;
   assign zero = flags_q.zero;
   assign neg  = flags_q.neg;

endmodule

// File: tb/tb_add32_pipe.sv
// Scoreboard bench for add32_pipe: accepted beats push a behavioural result,
// a separate monitor pops and compares whenever a result is consumed.
module tb_add32_pipe;
   import add32_pipe_pkg::*;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zero;
   logic         neg;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit chk_lat = 1'b0;

   typedef struct {
      logic [W-1:0] sum;
      logic [3:0]   fl;
      int           acc;
      bit           lat;
   } exp_t;

   exp_t sb[$];

   add32_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero),
      .neg       (neg)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   // Reference: two's-complement arithmetic on a widened sum.
   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic sv, input logic cv, input int c, input bit lat);
      exp_t         e;
      logic [W-1:0] bbv;
      logic [W:0]   r;
      bbv   = sv ? ~bv : bv;
      r     = {1'b0, av} + {1'b0, bbv} + {{W{1'b0}}, (sv | cv)};
      e.sum = r[W-1:0];
      e.fl  = {r[W], (av[W-1] == bbv[W-1]) && (e.sum[W-1] != av[W-1]),
               e.sum == '0, e.sum[W-1]};
      e.acc = c;
      e.lat = lat;
      return e;
   endfunction

   // Input side: check in_ready against occupancy, then record accepted beats.
   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         check("in_ready", in_ready, (sb.size() < 2) || out_ready);
         if (in_valid && in_ready) sb.push_back(model(a, b, sub, cin, cyc, chk_lat));
      end
   end

   logic [W-1:0] hold_sum;
   logic [3:0]   hold_fl;
   bit           holding = 1'b0;

   // Output side: compare consumed results and check stalled outputs hold.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         holding = 1'b0;
      end else begin
         if (holding && out_valid) begin
            check("hold_sum", sum, hold_sum);
            check("hold_flags", {cout, ovf, zero, neg}, hold_fl);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_result", out_valid, 1'b0);
            end else begin
               e = sb.pop_front();
               check("sum", sum, e.sum);
               check("flags", {cout, ovf, zero, neg}, e.fl);
               if (e.lat) check("latency", cyc - e.acc, 2);
            end
         end
         holding  = out_valid && !out_ready;
         hold_sum = sum;
         hold_fl  = {cout, ovf, zero, neg};
      end
   end

   // Offer one beat until accepted; called and returns at posedge+1.
   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sv, input logic cv);
      bit acc;
      int t;
      in_valid = 1'b1;
      a = av;
      b = bv;
      sub = sv;
      cin = cv;
      t = 0;
      acc = 1'b0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!acc && t < 50);
      if (!acc) timeout_fail("send");
      in_valid = 1'b0;
   endtask

   task automatic send_rand();
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic drain();
      int t;
      out_ready = 1'b1;
      t = 0;
      while (sb.size() != 0 && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (sb.size() != 0) timeout_fail("drain");
      repeat (2) begin
         @(posedge clk);
         #1;
      end
   endtask

   bit rnd_done;

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sum", sum, '0);
      check("rst_flags", {cout, ovf, zero, neg}, 4'b0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // Directed corner cases
      out_ready = 1'b1;
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
      send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0);
      send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
      send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);
      send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
      drain();

      // Streaming with latency tracking
      chk_lat = 1'b1;
      repeat (16) send_rand();
      drain();
      chk_lat = 1'b0;

      // Backpressure: two accepts fill the pipe, third beat must wait
      out_ready = 1'b0;
      send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
      send(32'h3333_3333, 32'h0000_0004, 1'b1, 1'b0);
      in_valid = 1'b1;
      a = 32'hDEAD_BEEF;
      b = 32'h0BAD_F00D;
      sub = 1'b0;
      cin = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", in_ready, 1'b0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1);
      drain();

      // Random valid and ready
      rnd_done = 1'b0;
      fork
         begin
            repeat (120) begin
               if ($urandom_range(0, 3) != 0) send_rand();
               else begin
                  @(posedge clk);
                  #1;
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      drain();

      // Reset with both stages full: nothing in flight may survive
      out_ready = 1'b0;
      send($urandom, $urandom, 1'b0, 1'b0);
      send($urandom, $urandom, 1'b1, 1'b0);
      @(negedge clk);
      check("full_out_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_sum", sum, '0);
      check("midrst_in_ready", in_ready, 1'b1);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      repeat (4) send_rand();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/add32_pipe.md
# add32_pipe

- Two-stage pipelined 32-bit adder/subtractor for the CPU datapath, built on 4-bit carry-lookahead groups.
- Stage 1 registers operands plus per-group propagate/generate (PS/GS).
- Stage 2 resolves the inter-group carries with a second lookahead level, then produces sum and flags.
- Sits between the operand-select stage and the ALU result mux; valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 32: operand width; must be a multiple of 4.
- NGRP, WIDTH/4: number of 4-bit lookahead groups (derived, not overridable).

Ports:
- clk  in  1  clock; everything samples on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- in_valid  in  1  operand beat is present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = compute a − b, 0 = compute a + b + cin.
- cin  in  1  carry-in; ignored when sub=1.
- out_valid  out  1  result is present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of bit WIDTH−1; for subtraction, 1 means no borrow.
- ovf  out  1  signed overflow = c[WIDTH] ^ c[WIDTH−1].
- zero  out  1  sum == 0.
- neg  out  1  sum[WIDTH−1].

## Operation
- Effective operands: bb = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage 1, on accept:
  - Register a, bb, c0.
  - Register per-bit p = a^bb and g = a&bb.
  - Register per-group PS = &p[4k+3:4k] and GS = standard 4-bit lookahead of g/p.
  - Set s1_valid.
- Stage 2, on advance:
  - Group carry-ins: C0 = c0; C(k+1) = GS(k) | PS(k)&C(k). Implement as a flat lookahead over all groups, never as a ripple across groups.
  - Intra-group carries: 4-bit lookahead from C(k).
  - sum = p ^ carries.
  - Register sum and all flags; set out_valid.
- Pipeline control (each stage is a full register, no skid buffer):
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready and the valid flags).
- Output registers change only when s2_adv and s1_valid.
- If s2_adv and !s1_valid, out_valid clears and data holds its old value.
- Width rule: all arithmetic is modulo 2^WIDTH; cout/ovf come from the carry chain, not from a widened adder.

## Timing
- Latency: beat accepted at edge N appears on the outputs after edge N+2 (out_valid high in cycle N+2) when out_ready is held high.
- Throughput: one beat per cycle under continuous in_valid and out_ready.
- Backpressure:
  - While out_valid && !out_ready, sum and the flags are held bit-stable.
  - With stage 1 full, in_ready = 0.
  - Maximum in flight = 2 beats.
- Simultaneous pop and push: with both stages full and out_ready = 1, in_ready = 1. The stage-1 beat moves to the outputs and the new beat enters stage 1 in the same edge.
- Reset: at an edge with rst_n low, the following all go to 0; in-flight beats are dropped:
  - s1_valid, out_valid
  - sum, cout, ovf, zero, neg
  - all stage-1 registers
- in_ready reads 1 in the first cycle after reset release.
- Handshake inputs are ignored in a reset cycle.

## Structure
- Shared package holds:
  - WIDTH default.
  - GRP_W = 4.
  - A flags struct/typedef {cout, ovf, zero, neg}, reused by the ALU result mux.
- One natural sub-module: cla_grp4. It is purely combinational and instantiated NGRP times in each stage.
  - Inputs: p[3:0], g[3:0], cin.
  - Outputs: c[4:1], PS, GS.
  - Stage 1 uses only PS/GS; stage 2 uses c[4:1].
- The second-level group lookahead lives in the top module as a generate loop.

## Test plan
- 0xFFFFFFFF + 0x00000001, cin = 0 → sum 0x00000000, cout 1, zero 1, ovf 0, neg 0, two cycles after accept.
- 0x7FFFFFFF + 0x00000001 → sum 0x80000000, ovf 1, neg 1, cout 0.
- sub = 1, a = 5, b = 7 → sum 0xFFFFFFFE, cout 0, neg 1, ovf 0; sub = 1, a = 7, b = 5 → sum 2, cout 1.
- Streaming, out_ready = 1: 16 back-to-back beats; 1 result per cycle in order, first result 2 cycles after first accept. Compare against a behavioural a+b+cin model.
- Backpressure:
  - out_ready low 3 cycles with 3 beats offered: in_ready drops after 2 accepts and outputs hold stable.
  - On out_ready re-high, results drain in order with no loss or duplication.
- Reset mid-flight: rst_n low 1 cycle with both stages full → out_valid 0 and sum 0 next cycle. No stale result emerges after release.
